// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
//   start  : request to add a/b/cin (master -> slave)
//   a, b   : unsigned operands, WIDTH bits (master -> slave)
//   cin    : carry into bit 0 (master -> slave)
//   busy   : addition in progress (slave -> master)
//   done   : one-cycle pulse, sum/cout freshly updated (slave -> master)
//   sum    : registered result, WIDTH bits (slave -> master)
//   cout   : registered carry out of the top bit (slave -> master)
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout, sum} = a + b + cin, one bit per clock, LSB first,
// using a single full-adder cell and a carry flip-flop.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if slave port (start/a/b/cin in, busy/done/sum/cout out)
// A start in IDLE captures the operands; SHIFT runs for WIDTH cycles; DONE lasts
// one cycle and then returns to IDLE. Starts outside IDLE are dropped.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_a_sr, w_a_sr_d;
  logic [WIDTH-1:0] r_b_sr, w_b_sr_d;
  logic [WIDTH-1:0] r_res_sr, w_res_sr_d;
  logic [WIDTH-1:0] r_sum, w_sum_d;
  logic             r_cout, w_cout_d;
  logic             r_carry, w_carry_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_res_shift;

  // Single full-adder cell on the operand LSBs and the carry FF.
  assign w_s    = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_c    = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
  assign w_last = (r_cnt == CntW'(WIDTH - 1));

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at position 0.
  if (WIDTH == 1) begin : g_res_w1
    assign w_res_shift = w_s;
  end else begin : g_res_wn
    assign w_res_shift = {w_s, r_res_sr[WIDTH-1:1]};
  end

  always_comb begin
    w_state_d  = r_state;
    w_a_sr_d   = r_a_sr;
    w_b_sr_d   = r_b_sr;
    w_res_sr_d = r_res_sr;
    w_sum_d    = r_sum;
    w_cout_d   = r_cout;
    w_carry_d  = r_carry;
    w_cnt_d    = r_cnt;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_a_sr_d  = bus.a;
          w_b_sr_d  = bus.b;
          w_carry_d = bus.cin;
          w_cnt_d   = '0;
          w_state_d = StShift;
        end
      end
      StShift: begin
        w_a_sr_d   = r_a_sr >> 1;
        w_b_sr_d   = r_b_sr >> 1;
        w_res_sr_d = w_res_shift;
        w_carry_d  = w_c;
        w_cnt_d    = r_cnt + CntW'(1);
        if (w_last) begin
          w_sum_d   = w_res_shift;
          w_cout_d  = w_c;
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_a_sr   <= w_a_sr_d;
      r_b_sr   <= w_b_sr_d;
      r_res_sr <= w_res_sr_d;
      r_sum    <= w_sum_d;
      r_cout   <= w_cout_d;
      r_carry  <= w_carry_d;
      r_cnt    <= w_cnt_d;
    end
  end

  assign bus.busy = (r_state == StShift);
  assign bus.done = (r_state == StDone);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a WIDTH=8 instance for the main checks and a
// WIDTH=1 instance for the full-adder truth table. Expected results are pushed
// on a queue when an operation starts and popped when done pulses.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) u_bus ();
  serial_adder_if #(.WIDTH(1)) u1_bus ();

  serial_adder #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_bus)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u1_bus)
  );

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [32:0] sb[$];
  logic [32:0] sb1[$];
  logic [32:0] last_res;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; the operands are captured at the next edge.
  task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin);
    u_bus.a     = op_a;
    u_bus.b     = op_b;
    u_bus.cin   = op_cin;
    u_bus.start = 1'b1;
    sb.push_back(33'({1'b0, op_a} + {1'b0, op_b} + {8'd0, op_cin}));
    @(negedge clk);
    u_bus.start = 1'b0;
  endtask

  // Entered on the first negedge after the capture edge. disturb_at > 0 re-drives
  // operands and start during SHIFT, which must have no effect.
  task automatic wait_done(input string tag, input int disturb_at);
    int          n;
    int          busy_cnt;
    logic [32:0] exp;
    n        = 1;
    busy_cnt = 0;
    while (u_bus.done !== 1'b1 && n <= 40) begin
      if (u_bus.busy === 1'b1) busy_cnt++;
      check({tag, "_hold"}, {u_bus.cout, u_bus.sum}, last_res);
      if (disturb_at > 0 && n == disturb_at) begin
        u_bus.a     = 8'hAA;
        u_bus.b     = 8'h55;
        u_bus.start = 1'b1;
      end
      if (disturb_at > 0 && n == disturb_at + 3) u_bus.start = 1'b0;
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 33'(u_bus.done), 33'd1);
    check({tag, "_latency"}, 33'(n), 33'(W + 1));
    check({tag, "_busy_cycles"}, 33'(busy_cnt), 33'(W));
    exp = (sb.size() > 0) ? sb.pop_front() : 'x;
    check({tag, "_result"}, {u_bus.cout, u_bus.sum}, exp);
    last_res = exp;
    @(negedge clk);
    check({tag, "_done_pulse"}, {u_bus.busy, u_bus.done}, 33'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          phase;
    int          last_done;
    int          n_done;
    logic        saw_done;
    logic [32:0] exp;
    logic [2:0]  combo;

    rst_n        = 1'b0;
    u_bus.start  = 1'b0;
    u_bus.a      = '0;
    u_bus.b      = '0;
    u_bus.cin    = 1'b0;
    u1_bus.start = 1'b0;
    u1_bus.a     = '0;
    u1_bus.b     = '0;
    u1_bus.cin   = 1'b0;
    last_res     = '0;

    // Reset applies before any clock edge.
    #1;
    check("rst_busy", 33'(u_bus.busy), 33'd0);
    check("rst_done", 33'(u_bus.done), 33'd0);
    check("rst_result", {u_bus.cout, u_bus.sum}, 33'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(8'h03, 8'h05, 1'b0);
    wait_done("add_03_05", 0);
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done("add_FF_01", 0);
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done("add_FF_FF_c", 0);

    // Operands and start re-driven at SHIFT cycle 3 must be ignored.
    start_op(8'h10, 8'h20, 1'b0);
    wait_done("add_disturb", 3);
    repeat (3) begin
      check("no_second_op", {u_bus.busy, u_bus.done}, 33'd0);
      @(negedge clk);
    end

    // Reset in the middle of SHIFT aborts the operation.
    start_op(8'h10, 8'h20, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 33'(u_bus.busy), 33'd0);
    check("midrst_done", 33'(u_bus.done), 33'd0);
    check("midrst_result", {u_bus.cout, u_bus.sum}, 33'd0);
    sb.delete();
    last_res = '0;
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (u_bus.done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", 33'(saw_done), 33'd0);
    start_op(8'h01, 8'h01, 1'b0);
    wait_done("add_after_rst", 0);

    // Start held high: a capture every W+2 edges, operands random every cycle.
    phase       = 0;
    last_done   = -1;
    n_done      = 0;
    u_bus.start = 1'b1;
    for (int i = 0; i < 4 * (W + 2); i++) begin
      if (u_bus.done === 1'b1) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check("b2b_result", {u_bus.cout, u_bus.sum}, exp);
        if (last_done >= 0) check("b2b_period", 33'(i - last_done), 33'(W + 2));
        last_done = i;
        n_done++;
      end
      u_bus.a   = W'($urandom);
      u_bus.b   = W'($urandom);
      u_bus.cin = 1'($urandom);
      if (phase == 0) begin
        sb.push_back(33'({1'b0, u_bus.a} + {1'b0, u_bus.b} + {8'd0, u_bus.cin}));
      end
      phase = (phase + 1) % (W + 2);
      @(negedge clk);
    end
    u_bus.start = 1'b0;
    check("b2b_count", 33'(n_done), 33'd4);
    check("b2b_queue_empty", 33'(sb.size()), 33'd0);

    // WIDTH=1 instance: full-adder truth table, done one edge after start.
    for (int c = 0; c < 8; c++) begin
      combo        = 3'(c);
      u1_bus.a     = combo[2];
      u1_bus.b     = combo[1];
      u1_bus.cin   = combo[0];
      u1_bus.start = 1'b1;
      sb1.push_back(33'({1'b0, combo[2]} + {1'b0, combo[1]} + {1'b0, combo[0]}));
      @(negedge clk);
      u1_bus.start = 1'b0;
      check("w1_busy", {u1_bus.busy, u1_bus.done}, 33'd2);
      @(negedge clk);
      check("w1_done", {u1_bus.busy, u1_bus.done}, 33'd1);
      exp = (sb1.size() > 0) ? sb1.pop_front() : 'x;
      check("w1_result", {u1_bus.cout, u1_bus.sum}, exp);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to add current a/b/cin; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A, unsigned.
REQ-006 b  input  WIDTH  operand B, unsigned.
REQ-007 cin  input  1  carry-in to bit 0.
REQ-008 busy  output  1  high while an addition is in progress (state SHIFT).
REQ-009 done  output  1  one-cycle pulse: sum/cout valid and newly updated.
REQ-010 sum  output  WIDTH  registered result bits, held until the next completion.
REQ-011 cout  output  1  registered carry-out of bit WIDTH-1, held as sum.

Function
REQ-012 Block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, one bit per clock, using one full-adder cell and a carry flip-flop.
REQ-013 FSM states SHALL be IDLE, SHIFT, DONE; encoding free; no other reachable states.
REQ-014 IDLE: start=1 at edge SHALL capture a, b into operand shift registers, load carry FF with cin, clear bit counter, go to SHIFT; start=0 SHALL stay IDLE.
REQ-015 SHIFT, each edge: s = a_sr[0]^b_sr[0]^c; c_next = majority(a_sr[0],b_sr[0],c); s enters internal result shift register at MSB, operands shift right by one, counter increments.
REQ-016 SHIFT SHALL last exactly WIDTH edges; on the WIDTH-th edge sum SHALL load the completed result register, cout SHALL load c_next, state goes to DONE.
REQ-017 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: start sampled at edge k -> busy=1 from edge k to edge k+WIDTH; done=1 from edge k+WIDTH to edge k+WIDTH+1; next start accepted at edge k+WIDTH+2 earliest.
REQ-019 busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE); both registered-state decodes, glitch-free.
REQ-020 start while in SHIFT or DONE SHALL be ignored (not queued); a/b/cin changes after capture SHALL NOT affect the result in progress.
REQ-021 sum and cout SHALL change only on the completion edge (REQ-016); during SHIFT they hold the previous result.
REQ-022 Wrap-around: a+b+cin >= 2^WIDTH SHALL yield sum = (a+b+cin) mod 2^WIDTH, cout=1; no other overflow indication.
REQ-023 WIDTH=1 SHALL work: one SHIFT cycle, result identical to a single full adder.
REQ-024 Each completed {cout,sum} SHALL equal the combinational full-adder-chain result of the captured operands, so a downstream ripple/full-adder checker can compare them directly.

Reset
REQ-025 rst_n=0 SHALL immediately, independent of clk, force state IDLE, busy=0, done=0, sum=0, cout=0, carry FF=0, counter=0, shift registers=0.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-027 After rst_n deasserts, first start SHALL be accepted on the first rising edge where start=1.

Verification (WIDTH=8 unless stated)
REQ-028 a=8'h03, b=8'h05, cin=0, start pulse -> done 8 edges after start edge, sum=8'h08, cout=0; busy high exactly 8 cycles.
REQ-029 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-030 Start accepted with a=8'h10, b=8'h20; at SHIFT cycle 3 drive a=8'hAA, b=8'h55, start=1 -> result sum=8'h30, cout=0; no second operation begins.
REQ-031 Start accepted, rst_n pulsed low at SHIFT cycle 4 -> busy, done, sum, cout all 0 immediately; no done pulse after release; new start a=8'h01, b=8'h01 -> sum=8'h02.
REQ-032 WIDTH=1, all 8 combinations of {a,b,cin} -> done 1 edge after start edge, {cout,sum} equals full-adder truth table each time.
REQ-033 Back-to-back: start held high continuously with random operands -> operations every WIDTH+2 cycles, every {cout,sum} matches a+b+cin of operands captured at its start edge.
